// File: rtl/halton_seq_gen.sv
// Radical-inverse (Halton / van der Corput) sample generator: base-BASE digit counter,
// weighted digit-reversed sum, 2-stage pipeline, ready/valid output. Optional SCRAMBLE_EN macro.
module halton_seq_gen #(
    parameter int BASE   = 3,
    parameter int DIGITS = 16,
    parameter int OUT_W  = 24,
    localparam int DIGIT_W = (BASE > 1) ? $clog2(BASE) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        seed_load,
    input  logic [DIGITS*DIGIT_W-1:0]   seed,
`ifdef SCRAMBLE_EN
    input  logic [DIGITS*DIGIT_W-1:0]   scramble_key,
`endif
    input  logic                        en,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [OUT_W-1:0]            out,
    output logic                        wrap
);

    localparam int SUM_W = OUT_W + ((DIGITS > 1) ? $clog2(DIGITS) : 1);
    localparam int TAB_N = 1 << DIGIT_W;
    localparam logic [DIGIT_W:0]   BASE_C = (DIGIT_W+1)'(BASE);
    localparam logic [DIGIT_W-1:0] MAX_D  = DIGIT_W'(BASE - 1);

    function automatic logic [127:0] base_pow(input int e);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < e; i++) begin
            p = p * 128'(BASE);
        end
        return p;
    endfunction

    // Round-half-up of d * 2^OUT_W / BASE^(k+1), done as floor((2n + den) / 2den).
    function automatic logic [OUT_W-1:0] weight(input int k, input int d);
        logic [127:0] den;
        logic [127:0] num;
        logic [127:0] q;
        den = base_pow(k + 1);
        num = 128'(d) << OUT_W;
        q   = ((num << 1) + den) / (den << 1);
        return q[OUT_W-1:0];
    endfunction

    logic [DIGIT_W-1:0] digit_reg  [DIGITS];
    logic [DIGIT_W-1:0] digit_next [DIGITS];
    logic [DIGIT_W-1:0] seed_digit [DIGITS];
    logic [DIGITS:0]    carry;
    logic [OUT_W-1:0]   w_reg      [DIGITS];
    logic [OUT_W-1:0]   w_next     [DIGITS];
    logic               v1_reg;
    logic               wrap1_reg;
    logic               wrap_pend_reg;
    logic               valid_reg;
    logic               wrap_reg;
    logic [OUT_W-1:0]   out_reg;
    logic [SUM_W-1:0]   sum_acc;
    logic [OUT_W-1:0]   sum_out;
    logic               stall;

`ifdef SCRAMBLE_EN
    logic [DIGIT_W-1:0] key_reg [DIGITS];
    logic [DIGIT_W-1:0] key_mod [DIGITS];
`endif

    assign stall    = valid_reg & ~out_ready;
    assign carry[0] = 1'b1;

    genvar gi;
    genvar gd;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] seed_d;
            logic [DIGIT_W-1:0] lookup_d;
            logic [OUT_W-1:0]   wtab [TAB_N];

            // Digit k advances only when every lower digit is at BASE-1.
            assign carry[gi+1]     = carry[gi] & (digit_reg[gi] == MAX_D);
            assign digit_next[gi]  = !carry[gi] ? digit_reg[gi] :
                                     (digit_reg[gi] == MAX_D) ? '0 : digit_reg[gi] + 1'b1;

            assign seed_d          = seed[gi*DIGIT_W +: DIGIT_W];
            assign seed_digit[gi]  = ({1'b0, seed_d} < BASE_C) ? seed_d : '0;

`ifdef SCRAMBLE_EN
            logic [DIGIT_W-1:0] key_d;
            logic [DIGIT_W:0]   shift_sum;
            assign key_d       = scramble_key[gi*DIGIT_W +: DIGIT_W];
            assign key_mod[gi] = ({1'b0, key_d} >= BASE_C) ? DIGIT_W'({1'b0, key_d} - BASE_C) : key_d;
            assign shift_sum   = {1'b0, digit_reg[gi]} + {1'b0, key_reg[gi]};
            assign lookup_d    = (shift_sum >= BASE_C) ? DIGIT_W'(shift_sum - BASE_C)
                                                       : DIGIT_W'(shift_sum);
`else
            assign lookup_d    = digit_reg[gi];
`endif

            // Weight table is fully elaborated; unused codes above BASE-1 read as zero.
            for (gd = 0; gd < TAB_N; gd++) begin : g_tab
                localparam logic [OUT_W-1:0] WV = (gd < BASE) ? weight(gi, gd) : '0;
                assign wtab[gd] = WV;
            end

            assign w_next[gi] = wtab[lookup_d];
        end
    endgenerate

    always_comb begin
        sum_acc = '0;
        for (int k = 0; k < DIGITS; k++) begin
            sum_acc = sum_acc + SUM_W'(w_reg[k]);
        end
    end

    assign sum_out = (|sum_acc[SUM_W-1:OUT_W]) ? '1 : sum_acc[OUT_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_reg[k] <= '0;
                w_reg[k]     <= '0;
            end
            v1_reg        <= 1'b0;
            wrap1_reg     <= 1'b0;
            wrap_pend_reg <= 1'b0;
            valid_reg     <= 1'b0;
            wrap_reg      <= 1'b0;
            out_reg       <= '0;
        end else if (seed_load) begin
            for (int k = 0; k < DIGITS; k++) begin
                digit_reg[k] <= seed_digit[k];
            end
            v1_reg        <= 1'b0;
            wrap1_reg     <= 1'b0;
            wrap_pend_reg <= 1'b0;
            valid_reg     <= 1'b0;
            wrap_reg      <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < DIGITS; k++) begin
                w_reg[k] <= w_next[k];
            end
            v1_reg    <= en;
            wrap1_reg <= en & wrap_pend_reg;
            out_reg   <= sum_out;
            valid_reg <= v1_reg;
            wrap_reg  <= wrap1_reg;
            if (en) begin
                for (int k = 0; k < DIGITS; k++) begin
                    digit_reg[k] <= digit_next[k];
                end
                // Remember a roll-over so the zero index it produced is tagged when sampled.
                wrap_pend_reg <= carry[DIGITS];
            end
        end
    end

`ifdef SCRAMBLE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DIGITS; k++) begin
                key_reg[k] <= '0;
            end
        end else if (seed_load) begin
            for (int k = 0; k < DIGITS; k++) begin
                key_reg[k] <= key_mod[k];
            end
        end
    end
`endif

    assign out_valid = valid_reg;
    assign out       = out_reg;
    assign wrap      = wrap_reg;

endmodule

// File: tb/tb_halton_seq_gen.sv
// Bench for halton_seq_gen: three parameterisations, table vectors, directed corner
// sequences and a randomized scoreboard run against an arithmetic radical-inverse model.
module tb_halton_seq_gen;

    localparam int N = 3;
    localparam int BASES [N] = '{3, 3, 2};
    localparam int DIGS  [N] = '{16, 2, 16};
    localparam int DWS   [N] = '{2, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        seed_load_s [N];
    logic        en_s        [N];
    logic        ready_s     [N];
    logic [31:0] seed_s      [N];
    logic        valid_s     [N];
    logic        wrap_s      [N];
    logic [23:0] out_s       [N];
`ifdef SCRAMBLE_EN
    logic [31:0] key_s       [N];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int SW = DIGS[gi] * DWS[gi];
        halton_seq_gen #(.BASE(BASES[gi]), .DIGITS(DIGS[gi]), .OUT_W(24)) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .seed_load    (seed_load_s[gi]),
            .seed         (seed_s[gi][SW-1:0]),
`ifdef SCRAMBLE_EN
            .scramble_key (key_s[gi][SW-1:0]),
`endif
            .en           (en_s[gi]),
            .out_ready    (ready_s[gi]),
            .out_valid    (valid_s[gi]),
            .out          (out_s[gi]),
            .wrap         (wrap_s[gi])
        );
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s: got %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Radical inverse from first principles: digit k weighs 1/BASE^(k+1), each term rounded.
    function automatic longint ri(input int inst, input longint idx, input int key0);
        longint unsigned s, pw, x, d;
        s = 0; pw = 1; x = idx;
        for (int k = 0; k < DIGS[inst]; k++) begin
            pw = pw * longint'(BASES[inst]);
            d  = x % longint'(BASES[inst]);
            x  = x / longint'(BASES[inst]);
            if (k == 0) d = (d + longint'(key0)) % longint'(BASES[inst]);
            if (d != 0) s = s + (2 * d * (64'd1 << 24) + pw) / (2 * pw);
        end
        if (s >= (64'd1 << 24)) s = (64'd1 << 24) - 1;
        return longint'(s);
    endfunction

    function automatic longint dec(input int inst, input logic [31:0] sd);
        longint idx, pw;
        int d;
        idx = 0; pw = 1;
        for (int k = 0; k < DIGS[inst]; k++) begin
            d = 0;
            for (int b = 0; b < DWS[inst]; b++) d = d | (int'(sd[k*DWS[inst] + b]) << b);
            if (d >= BASES[inst]) d = 0;
            idx = idx + longint'(d) * pw;
            pw  = pw * longint'(BASES[inst]);
        end
        return idx;
    endfunction

    typedef struct {
        int          inst;
        logic [31:0] seed;
        logic [23:0] exp_out;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [14];

    task automatic run_random(input int inst, input int cycles);
        longint q[$];
        longint idx, period, e_ent;
        logic   pend, sl, e, r, stall;
        logic [31:0] sd;
        idx = 0; pend = 1'b0; period = 1;
        for (int k = 0; k < DIGS[inst]; k++) period = period * longint'(BASES[inst]);
        for (int c = 0; c < cycles + 6; c++) begin
            sl = (c == 0) || (c < cycles && $urandom_range(0, 39) == 0);
            e  = (c < cycles) && ($urandom_range(0, 3) != 0);
            r  = (c >= cycles) || ($urandom_range(0, 3) != 0);
            sd = $urandom;
            if ($urandom_range(0, 1) == 1) sd = sd | ((inst == 2) ? 32'h0000FFF0 : 32'hAAAAAAA0);
            seed_load_s[inst] = sl;
            en_s[inst]        = e;
            ready_s[inst]     = r;
            seed_s[inst]      = sd;
            stall = valid_s[inst] & ~r;
            if (valid_s[inst]) begin
                if (q.size() == 0) begin
                    chk("rand valid_without_sample", longint'(valid_s[inst]), 0);
                end else begin
                    e_ent = q[0];
                    chk("rand out", longint'(out_s[inst]), ri(inst, e_ent >> 1, 0));
                    chk("rand wrap", longint'(wrap_s[inst]), e_ent & 1);
                    if (r) void'(q.pop_front());
                end
            end
            if (sl) begin
                q.delete();
                idx  = dec(inst, sd);
                pend = 1'b0;
            end else if (e && !stall) begin
                q.push_back(idx * 2 + longint'(pend));
                if (idx == period - 1) begin
                    idx = 0; pend = 1'b1;
                end else begin
                    idx = idx + 1; pend = 1'b0;
                end
            end
            tick();
        end
        chk("rand drained", longint'(q.size()), 0);
    endtask

    initial begin
        int inst;
        vecs[0]  = '{0, 32'h0, 24'h000000, 1'b0};
        vecs[1]  = '{0, 32'h1, 24'h555555, 1'b0};
        vecs[2]  = '{0, 32'h2, 24'hAAAAAB, 1'b0};
        vecs[3]  = '{0, 32'h4, 24'h1C71C7, 1'b0};
        vecs[4]  = '{0, 32'h5, 24'h71C71C, 1'b0};
        vecs[5]  = '{0, 32'hA, 24'hE38E39, 1'b0};
        vecs[6]  = '{0, 32'h3, 24'h000000, 1'b0};
        vecs[7]  = '{2, 32'h1, 24'h800000, 1'b0};
        vecs[8]  = '{2, 32'h2, 24'h400000, 1'b0};
        vecs[9]  = '{2, 32'h3, 24'hC00000, 1'b0};
        vecs[10] = '{2, 32'h4, 24'h200000, 1'b0};
        vecs[11] = '{1, 32'h7, 24'h1C71C7, 1'b0};
        vecs[12] = '{1, 32'hF, 24'h000000, 1'b0};
        vecs[13] = '{1, 32'h6, 24'hC71C72, 1'b0};

        reset_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            seed_load_s[i] = 1'b0; en_s[i] = 1'b0; ready_s[i] = 1'b0; seed_s[i] = '0;
`ifdef SCRAMBLE_EN
            key_s[i] = '0;
`endif
        end
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        chk("reset valid", longint'(valid_s[0]), 0);
        chk("reset out", longint'(out_s[0]), 0);
        chk("reset wrap", longint'(wrap_s[0]), 0);
        chk("reset valid b2", longint'(valid_s[2]), 0);

        // Continuous stream from reset, with a 5-cycle stall on the third sample.
        en_s[0] = 1'b1; ready_s[0] = 1'b1;
        tick(); chk("stream latency", longint'(valid_s[0]), 0);
        tick(); chk("stream valid", longint'(valid_s[0]), 1); chk("stream s0", longint'(out_s[0]), 24'h000000);
        tick(); chk("stream s1", longint'(out_s[0]), 24'h555555);
        tick(); chk("stream s2", longint'(out_s[0]), 24'hAAAAAB);
        ready_s[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall hold", longint'(out_s[0]), 24'hAAAAAB);
            chk("stall valid", longint'(valid_s[0]), 1);
        end
        ready_s[0] = 1'b1;
        tick(); chk("after stall s3", longint'(out_s[0]), 24'h1C71C7);
        tick(); chk("after stall s4", longint'(out_s[0]), 24'h71C71C);

        // Asynchronous reset between edges.
        #3 reset_n = 1'b0;
        #1;
        chk("async reset valid", longint'(valid_s[0]), 0);
        chk("async reset out", longint'(out_s[0]), 0);
        chk("async reset wrap", longint'(wrap_s[0]), 0);
        #1 reset_n = 1'b1;
        tick(); chk("restart latency", longint'(valid_s[0]), 0);
        tick(); chk("restart s0", longint'(out_s[0]), 24'h000000); chk("restart valid", longint'(valid_s[0]), 1);
        tick(); chk("restart s1", longint'(out_s[0]), 24'h555555);
        en_s[0] = 1'b0;
        tick();

        // Table vectors: load seed, one en pulse, expect sample exactly 2 cycles later.
        for (int i = 0; i < 14; i++) begin
            inst = vecs[i].inst;
            seed_s[inst] = vecs[i].seed; seed_load_s[inst] = 1'b1; ready_s[inst] = 1'b1;
            tick();
            seed_load_s[inst] = 1'b0; en_s[inst] = 1'b1;
            tick();
            en_s[inst] = 1'b0;
            chk($sformatf("vec%0d latency", i), longint'(valid_s[inst]), 0);
            tick();
            chk($sformatf("vec%0d valid", i), longint'(valid_s[inst]), 1);
            chk($sformatf("vec%0d out", i), longint'(out_s[inst]), longint'(vecs[i].exp_out));
            chk($sformatf("vec%0d wrap", i), longint'(wrap_s[inst]), longint'(vecs[i].exp_wrap));
            tick();
            chk($sformatf("vec%0d bubble", i), longint'(valid_s[inst]), 0);
        end

        // Roll-over on the 2-digit instance: index 8 -> 0 (wrap) -> 1.
        seed_s[1] = 32'hA; seed_load_s[1] = 1'b1; ready_s[1] = 1'b1;
        tick();
        seed_load_s[1] = 1'b0; en_s[1] = 1'b1;
        tick(); tick();
        chk("wrap idx8 out", longint'(out_s[1]), 24'hE38E39); chk("wrap idx8 flag", longint'(wrap_s[1]), 0);
        tick();
        chk("wrap idx0 out", longint'(out_s[1]), 24'h000000); chk("wrap idx0 flag", longint'(wrap_s[1]), 1);
        tick();
        chk("wrap idx1 out", longint'(out_s[1]), 24'h555555); chk("wrap idx1 flag", longint'(wrap_s[1]), 0);
        en_s[1] = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            run_random(i, 700);
            en_s[i] = 1'b0; seed_load_s[i] = 1'b0;
        end

`ifdef SCRAMBLE_EN
        key_s[0] = 32'h1; seed_s[0] = '0; seed_load_s[0] = 1'b1; ready_s[0] = 1'b1;
        tick();
        seed_load_s[0] = 1'b0; en_s[0] = 1'b1;
        tick(); tick();
        chk("scramble s0", longint'(out_s[0]), ri(0, 0, 1));
        chk("scramble s0 const", longint'(out_s[0]), 24'h555555);
        tick(); chk("scramble s1", longint'(out_s[0]), 24'hAAAAAB);
        tick(); chk("scramble s2", longint'(out_s[0]), 24'h000000);
        en_s[0] = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/halton_seq_gen.md
Name: halton_seq_gen

Overview:
- Parametrised radical-inverse (Halton / van der Corput) sequence generator for stochastic-computing bitstream generation.
- Holds a base-BASE digit counter and converts each index to an OUT_W-bit fraction in [0,1) by digit-reversed weighted summation.
- Adds a 2-stage registered pipeline, ready/valid output, seed reload and wrap flag.
- Any prime base is supported; one instance per SNG channel.

Parameters:
- BASE, 3: radix of the sequence; prime, 2..31.
- DIGITS, 16: number of base-BASE counter digits; period is BASE^DIGITS.
- OUT_W, 24: output fraction width, 8..32.
- DIGIT_W, clog2(BASE): localparam, bits per stored digit (2 for BASE=3, 1 for BASE=2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  load seed into counter; flushes pipeline.
- seed  in  DIGITS*DIGIT_W  starting index, digit k at [k*DIGIT_W +: DIGIT_W], digit 0 least significant.
- en  in  1  request one new sample this cycle.
- out_ready  in  1  consumer accepts out this cycle.
- out_valid  out  1  out/wrap hold a valid sample.
- out  out  OUT_W  radical inverse of the sample index, unsigned fraction scaled by 2^OUT_W.
- wrap  out  1  qualified by out_valid; sample is index 0 reached by counter roll-over.

Behaviour:
- Reset (reset_n low, async):
  - counter, stage-1 weight registers, v1, out, out_valid and wrap all clear to 0.
  - Counter restarts at index 0 on release.
- stall = out_valid & !out_ready. When stall is high, nothing in the block updates (counter, stage 1, stage 2 all hold), and out/wrap stay stable.
- When !stall:
  - Stage 1 registers w[k] = W(k, digit_k) for every digit, v1 <= en, wrap1 <= roll-over pending flag.
  - Stage 2 registers out <= sum of w[k], out_valid <= v1, wrap <= wrap1.
  - If en, the counter increments by 1 in base BASE: digit k increments iff all lower digits equal BASE-1; a digit at BASE-1 that increments becomes 0.
- Latency: the sample for the current index appears on out exactly 2 cycles after the en cycle with no stall. Throughput is 1 sample/clk.
- Weights are elaboration-time constants: W(k,d) = round-half-up(d * 2^OUT_W / BASE^(k+1)). They are computed by a constant function in 128-bit integer arithmetic, with W(k,0)=0.
- Sum arithmetic: accumulate in OUT_W+clog2(DIGITS) bits. If the rounded sum is >= 2^OUT_W, saturate out to all ones; otherwise truncate to OUT_W.
- Wrap-around:
  - A counter at all digits BASE-1 that increments goes to all zeros.
  - That zero-index sample is emitted with wrap=1; every other sample has wrap=0.
- seed_load (synchronous, priority over en and over stall):
  - counter <= seed, with any digit >= BASE replaced by 0.
  - v1 and out_valid clear, and the pending wrap clears.
  - The first sample after the load is the seed index, 2 cycles after the next en.
- en low with !stall inserts a bubble (out_valid drops after 2 cycles). en high during stall is ignored: no increment and no lost index.
- Reset asserted mid-operation discards all in-flight samples immediately.

Optional Feature:
- SCRAMBLE_EN defined:
  - Adds input scramble_key [DIGITS*DIGIT_W-1:0], latched on seed_load and on reset release (reset value 0).
  - Stage 1 uses digit d' = (d + key_k) mod BASE before the weight lookup (random digit-shift scrambling). The counter itself is unaffected.
  - Keys >= BASE are reduced mod BASE when latched.
- SCRAMBLE_EN undefined: port absent; d' = d.

Test Plan:
- BASE=3, OUT_W=24, reset then en=1, out_ready=1 continuous -> out_valid rises 2 cycles after first en. out sequence 0x000000, 0x555555, 0xAAAAAB, 0x1C71C7, 0x71C71C.
- Backpressure: same stream, out_ready=0 for 5 cycles while showing 0xAAAAAB -> out holds 0xAAAAAB, counter frozen. After release, next value is 0x1C71C7 with no skipped or duplicated index.
- Wrap: BASE=3, DIGITS=2, seed_load with seed digits {2,2} (index 8), en=1 -> out 0xE38E39 with wrap=0, then 0x000000 with wrap=1, then 0x555555 with wrap=0.
- BASE=2, OUT_W=24, seed 0, en=1 -> 0x000000, 0x800000, 0x400000, 0xC00000, 0x200000. Also seed_load of an invalid digit (BASE=3, digit value 3) loads as 0.
- Async reset: drive reset_n low between clock edges mid-stream -> out_valid, out and wrap go to 0 immediately. After release with en=1, the stream restarts at 0x000000.
- SCRAMBLE_EN, BASE=3: key digit0=1, seed 0, en=1 -> first three outputs 0x555555, 0xAAAAAB, 0x000000.
